led_frame_serializer: RTL and testbench
=======================================

Name: led_frame_serializer

Overview:
Upstream stage of the WS2812 bit transmitter. It fetches 24-bit GRB pixel words from the frame buffer over a 1-cycle-latency read port. It serializes each word MSB-first onto bit_to_transmit, advancing one bit per new_bit_rqst pulse, and flags all_bits_shifted after the last bit of the last LED. A new_frame_rqst pulse from the transmitter, issued at the end of its reset/latch time, restarts serialization from LED 0.

Parameters:
NUM_LEDS, 8, number of LEDs in the stripe (≥1)
BITS_PER_LED, 24, bits per pixel word (GRB, MSB = G[7])
ADDR_W, 8, pixel address width; 2^ADDR_W ≥ NUM_LEDS

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
new_bit_rqst  input  1  1-cycle pulse from transmitter: current bit consumed, present next
new_frame_rqst  input  1  1-cycle pulse from transmitter: start a new frame
bit_to_transmit  output  1  current bit (registered)
all_bits_shifted  output  1  high when no bits remain in the current frame
pix_addr  output  ADDR_W  frame-buffer read address (registered)
pix_data  input  BITS_PER_LED  frame-buffer read data, valid 1 cycle after pix_addr
frame_sync  output  1  1-cycle pulse when a frame fetch starts (buffer-swap point for game logic)
frame_done  output  1  1-cycle pulse when the last bit of the frame is consumed

Behaviour:
- Reset (rst=1 at posedge): state IDLE, bit_to_transmit=0, all_bits_shifted=1, pix_addr=0, frame_sync=0, frame_done=0, bit/LED counters=0, shift and prefetch registers=0.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE/DONE: outputs hold (bit_to_transmit=0, all_bits_shifted=1); new_bit_rqst is ignored. new_frame_rqst → FETCH, pix_addr<=0, frame_sync=1 for that cycle.
- FETCH (exactly 1 cycle):
  - shreg<=pix_data; bit_to_transmit<=pix_data[MSB]; all_bits_shifted<=0.
  - pix_addr<=1 when NUM_LEDS>1.
  - → SHIFT.
- SHIFT:
  - The cycle after FETCH, prefetch<=pix_data (LED 1). The prefetch register is reloaded the cycle after every pix_addr change.
  - new_bit_rqst with bit_cnt<BITS_PER_LED-1: shreg shifts left 1, bit_cnt+1; bit_to_transmit shows the new MSB on the next cycle.
  - new_bit_rqst with bit_cnt=BITS_PER_LED-1 and led_idx<NUM_LEDS-1: shreg<=prefetch, led_idx+1, bit_cnt<=0, pix_addr<=led_idx+2 if led_idx+2<NUM_LEDS, else pix_addr holds.
  - new_bit_rqst with bit_cnt=BITS_PER_LED-1 and led_idx=NUM_LEDS-1: → DONE, all_bits_shifted<=1, bit_to_transmit<=0, frame_done=1 for one cycle.
- Latency: the updated bit_to_transmit is visible exactly 1 cycle after new_bit_rqst; all_bits_shifted rises 1 cycle after the final new_bit_rqst.
- Pulse spacing: the transmitter guarantees ≥3 clk cycles between new_bit_rqst pulses and ≥2 cycles from new_frame_rqst to the first new_bit_rqst. Under that spacing the prefetch is always valid before use; closer spacing is outside contract.
- new_frame_rqst during SHIFT aborts the frame: → FETCH from LED 0, frame_sync pulses, no frame_done.
- new_frame_rqst and new_bit_rqst in the same cycle: frame request wins; the bit request is dropped.
- new_frame_rqst during FETCH: restarts FETCH (pix_addr<=0, frame_sync pulses again).
- NUM_LEDS=1: no prefetch address is issued; the frame ends after BITS_PER_LED requests.
- Counters: bit_cnt is clog2(BITS_PER_LED) bits wide; led_idx is ADDR_W bits; no wrap is reachable within contract.
- rst mid-frame: immediate return to IDLE with reset values on the next edge.

Test Plan:
- Reset: hold rst 2 cycles → bit_to_transmit=0, all_bits_shifted=1, pix_addr=0, no pulses; new_bit_rqst pulses in IDLE → no change.
- Single frame, NUM_LEDS=2, RAM[0]=24'hA5_0F_F0, RAM[1]=24'h00_00_01, pulse new_frame_rqst then 48 new_bit_rqst spaced 4 cycles → serial stream 1010_0101_0000_1111_1111_0000 then 23×0,1. frame_sync once; frame_done and all_bits_shifted rise 1 cycle after the 48th request.
- Addressing: same run → pix_addr sequence 0,1 and no address ≥2 issued; LED 1 bit 0 appears 1 cycle after the 24th request.
- Abort: new_frame_rqst after 30 bit requests → restart at RAM[0] MSB (1) 2 cycles later; frame_sync pulses, frame_done does not.
- Collision: new_frame_rqst and new_bit_rqst in the same cycle mid-frame → behaves as a pure restart; bit count from 0.
- Mid-frame rst: assert rst during LED 1 → next cycle all outputs at reset values; a subsequent new_frame_rqst replays the frame correctly from LED 0.

Source files
------------

// File: rtl/led_frame_serializer.sv
// Turns frame-buffer pixel words into an MSB-first bit stream. Each new_bit_rqst produces the next bit on the
// following cycle. The next pixel is prefetched over the 1-cycle read port, and new_frame_rqst always restarts from LED 0.
module led_frame_serializer #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int ADDR_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_bit_rqst,
  input  logic                    new_frame_rqst,
  output logic                    bit_to_transmit,
  output logic                    all_bits_shifted,
  output logic [ADDR_W-1:0]       pix_addr,
  input  logic [BITS_PER_LED-1:0] pix_data,
  output logic                    frame_sync,
  output logic                    frame_done
);

  localparam int CNT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS_PER_LED - 1);
  localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [BITS_PER_LED-1:0] shreg, prefetch, shreg_shl;
  logic [CNT_W-1:0]        bit_cnt;
  logic [ADDR_W-1:0]       led_idx;
  logic [ADDR_W:0]         nxt_addr;
  logic                    pf_load;
  logic                    start, load_first, do_shift, do_next, do_finish;

  assign shreg_shl = shreg << 1;
  assign nxt_addr  = {1'b0, led_idx} + (ADDR_W+1)'(2);

  // A frame request always wins, including over a coincident bit request.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    load_first = 1'b0;
    do_shift   = 1'b0;
    do_next    = 1'b0;
    do_finish  = 1'b0;
    if (new_frame_rqst) begin
      state_nxt = FETCH;
      start     = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          state_nxt  = SHIFT;
          load_first = 1'b1;
        end
        SHIFT: begin
          if (new_bit_rqst) begin
            if (bit_cnt != LAST_BIT) begin
              do_shift = 1'b1;
            end else if (led_idx != LAST_LED) begin
              do_next = 1'b1;
            end else begin
              do_finish = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bit_to_transmit  <= 1'b0;
      all_bits_shifted <= 1'b1;
      pix_addr         <= '0;
      frame_sync       <= 1'b0;
      frame_done       <= 1'b0;
      bit_cnt          <= '0;
      led_idx          <= '0;
      shreg            <= '0;
      prefetch         <= '0;
      pf_load          <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_sync <= start;
      frame_done <= do_finish;
      pf_load    <= 1'b0;
      // Prefetch captures read data one cycle after each address change.
      if (pf_load) prefetch <= pix_data;
      if (start) begin
        pix_addr <= '0;
        bit_cnt  <= '0;
        led_idx  <= '0;
        pf_load  <= 1'b1;
      end
      if (load_first) begin
        shreg            <= pix_data;
        bit_to_transmit  <= pix_data[BITS_PER_LED-1];
        all_bits_shifted <= 1'b0;
        if (NUM_LEDS > 1) begin
          pix_addr <= ADDR_W'(1);
          pf_load  <= 1'b1;
        end
      end
      if (do_shift) begin
        shreg           <= shreg_shl;
        bit_to_transmit <= shreg_shl[BITS_PER_LED-1];
        bit_cnt         <= bit_cnt + 1'b1;
      end
      if (do_next) begin
        shreg           <= prefetch;
        bit_to_transmit <= prefetch[BITS_PER_LED-1];
        led_idx         <= led_idx + 1'b1;
        bit_cnt         <= '0;
        if (nxt_addr < (ADDR_W+1)'(NUM_LEDS)) begin
          pix_addr <= nxt_addr[ADDR_W-1:0];
          pf_load  <= 1'b1;
        end
      end
      if (do_finish) begin
        all_bits_shifted <= 1'b1;
        bit_to_transmit  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: a flat bit-index model of the frame, compared on every cycle, plus literal stream checks.
module tb_led_frame_serializer;
  localparam int N   = 2;
  localparam int W   = 24;
  localparam int AW  = 8;
  localparam int TOT = N * W;

  typedef struct packed {
    logic          b;
    logic          a;
    logic          s;
    logic          d;
    logic [AW-1:0] addr;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst, new_bit_rqst, new_frame_rqst;
  logic          bit_to_transmit, all_bits_shifted, frame_sync, frame_done;
  logic [AW-1:0] pix_addr;
  logic [W-1:0]  pix_data;
  logic [W-1:0]  ram [256];

  int checks = 0;
  int errors = 0;
  int sync_cnt = 0, done_cnt = 0, max_addr = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  assign pix_data = ram[pix_addr];

  led_frame_serializer #(.NUM_LEDS(N), .BITS_PER_LED(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .new_bit_rqst(new_bit_rqst), .new_frame_rqst(new_frame_rqst),
    .bit_to_transmit(bit_to_transmit), .all_bits_shifted(all_bits_shifted),
    .pix_addr(pix_addr), .pix_data(pix_data), .frame_sync(frame_sync), .frame_done(frame_done)
  );

  // Reference: frame position is a single bit index k over all LEDs.
  bit            m_fetch = 0, m_active = 0;
  int            m_k = 0;
  logic          m_bit = 0, m_abs = 1, m_sync = 0, m_done = 0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_fetch = 0; m_active = 0; m_k = 0;
      m_bit = 0; m_abs = 1; m_sync = 0; m_done = 0; m_addr = '0;
    end else begin
      m_sync = 0;
      m_done = 0;
      if (new_frame_rqst) begin
        m_fetch = 1; m_active = 0; m_sync = 1; m_addr = '0;
      end else if (m_fetch) begin
        m_fetch = 0; m_active = 1; m_k = 0;
        m_bit = ram[0][W-1]; m_abs = 0;
        m_addr = (N > 1) ? AW'(1) : AW'(0);
      end else if (m_active && new_bit_rqst) begin
        m_k++;
        if (m_k == TOT) begin
          m_active = 0; m_bit = 0; m_abs = 1; m_done = 1;
        end else begin
          m_bit  = ram[m_k / W][W - 1 - (m_k % W)];
          m_addr = AW'((m_k / W + 1 < N) ? (m_k / W + 1) : (N - 1));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bit_to_transmit !== m_bit || all_bits_shifted !== m_abs || pix_addr !== m_addr ||
          frame_sync !== m_sync || frame_done !== m_done) begin
        errors++;
        $display("FAIL cycle_model t=%0t got bit=%b abs=%b addr=%0d sync=%b done=%b expected bit=%b abs=%b addr=%0d sync=%b done=%b",
                 $time, bit_to_transmit, all_bits_shifted, pix_addr, frame_sync, frame_done,
                 m_bit, m_abs, m_addr, m_sync, m_done);
      end
      if (frame_sync) sync_cnt++;
      if (frame_done) done_cnt++;
      if (int'(pix_addr) > max_addr) max_addr = int'(pix_addr);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    s.b = bit_to_transmit; s.a = all_bits_shifted; s.s = frame_sync; s.d = frame_done; s.addr = pix_addr;
    return s;
  endfunction

  // One-cycle pulse, snapshot of outputs the cycle after, then gap-1 idle cycles.
  task automatic step(input logic b, input logic f, input int gap, output snap_t cap);
    @(negedge clk);
    new_bit_rqst = b; new_frame_rqst = f;
    @(negedge clk);
    new_bit_rqst = 0; new_frame_rqst = 0;
    cap = snap();
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run_frame(input logic with_bit, output logic [TOT-1:0] s, output snap_t fetch_cap, output snap_t last);
    snap_t c;
    step(with_bit, 1'b1, 3, fetch_cap);
    s[TOT-1] = bit_to_transmit;
    for (int i = 1; i <= TOT; i++) begin
      step(1'b1, 1'b0, 3, c);
      if (i < TOT) s[TOT-1-i] = c.b;
      else last = c;
    end
  endtask

  task automatic requests(input int n);
    snap_t c;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3, c);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [TOT-1:0] stream;
    logic [TOT-1:0] golden;
    snap_t c, fc, last;
    int s0, d0;

    golden = {24'hA50FF0, 24'h000001};
    rst = 1; new_bit_rqst = 0; new_frame_rqst = 0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[0] = 24'hA50FF0;
    ram[1] = 24'h000001;

    repeat (2) @(negedge clk);
    chk("reset_state", snap(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    mon_en = 1;
    rst = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3, c);
    chk("idle_ignores_bits", c, {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});

    run_frame(1'b0, stream, fc, last);
    chk("fetch_sync_addr", {fc.s, fc.addr}, {1'b1, 8'd0});
    chk("frame_stream", stream, golden);
    chk("frame_end", {last.b, last.a, last.d}, {1'b0, 1'b1, 1'b1});
    #1;
    chk("sync_count", sync_cnt, 1);
    chk("done_count", done_cnt, 1);
    chk("max_addr", max_addr, 1);
    requests(2);
    chk("done_ignores_bits", {bit_to_transmit, all_bits_shifted, frame_done}, {1'b0, 1'b1, 1'b0});

    // Abort after 30 requests: restart shows RAM[0] MSB two cycles after the request.
    s0 = sync_cnt; d0 = done_cnt;
    step(1'b0, 1'b1, 3, c);
    requests(30);
    chk("pre_abort_bit", bit_to_transmit, 1'b0);
    @(negedge clk); new_frame_rqst = 1;
    @(negedge clk); new_frame_rqst = 0;
    @(negedge clk);
    chk("abort_restart", {bit_to_transmit, all_bits_shifted}, {1'b1, 1'b0});
    #1;
    chk("abort_sync_pulses", sync_cnt - s0, 2);
    chk("abort_no_done", done_cnt - d0, 0);
    @(negedge clk);

    // Collision mid-frame: must behave as a plain restart.
    requests(10);
    run_frame(1'b1, stream, fc, last);
    chk("collision_stream", stream, golden);
    chk("collision_end", {last.a, last.d}, {1'b1, 1'b1});

    // Reset during LED 1, then a clean replay.
    step(1'b0, 1'b1, 3, c);
    requests(30);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("midframe_reset", snap(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    run_frame(1'b0, stream, fc, last);
    chk("replay_stream", stream, golden);
    chk("replay_end", {last.b, last.a, last.d}, {1'b0, 1'b1, 1'b1});

    // Randomized frames with sporadic aborts, collisions and resets.
    for (int f = 0; f < 12; f++) begin
      @(negedge clk);
      ram[0] = W'($urandom);
      ram[1] = W'($urandom);
      new_frame_rqst = 1;
      @(negedge clk);
      new_frame_rqst = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      for (int e = 0; e < 60; e++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2) begin
          @(negedge clk); rst = 1;
          @(negedge clk); rst = 0;
        end else if (r < 5) begin
          step(1'($urandom_range(0, 1)), 1'b1, $urandom_range(2, 5), c);
        end else begin
          step(1'b1, 1'b0, $urandom_range(2, 5), c);
        end
      end
    end

    repeat (3) @(negedge clk);
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
